// File: rtl/mmc_pkg.sv
// Shared state encodings and constants for the MMC/SD SPI-mode engine.
package mmc_pkg;

    typedef enum logic [3:0] {
        StIdle = 4'd0,
        StInit = 4'd1,
        StCmd  = 4'd2,
        StResp = 4'd3,
        StXfer = 4'd4,
        StStop = 4'd5,
        StDone = 4'd6
    } mmc_state_e;

    localparam logic [7:0]  MMC_IDLE_BYTE  = 8'hFF;
    localparam int unsigned MMC_INIT_BYTES = 10;

    function automatic int unsigned mmc_max3(int unsigned a, int unsigned b, int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/mmc_spi_engine_if.sv
// CPU request/status bus plus the card-side SPI pins of the MMC engine.
interface mmc_spi_engine_if #(
    parameter int unsigned CMD_BYTES = 6
);
    logic                   speed;
    logic                   init;
    logic                   send;
    logic                   rd;
    logic                   wr;
    logic                   stop;
    logic [8*CMD_BYTES-1:0] cmd;
    logic [7:0]             data_in;
    logic [7:0]             data_out;
    logic                   busy;
    logic                   done;
    logic                   timeout;
    logic [3:0]             state_out;
    logic                   mmc_cs;
    logic                   mmc_di;
    logic                   mmc_do;
    logic                   mmc_sclk;

    modport master (
        output speed, init, send, rd, wr, stop, cmd, data_in, mmc_di,
        input  data_out, busy, done, timeout, state_out, mmc_cs, mmc_do, mmc_sclk
    );

    modport slave (
        input  speed, init, send, rd, wr, stop, cmd, data_in, mmc_di,
        output data_out, busy, done, timeout, state_out, mmc_cs, mmc_do, mmc_sclk
    );
endinterface

// File: rtl/mmc_spi_byte.sv
// SPI mode-0 byte shifter with its own sclk divider; one byte per start pulse.
module mmc_spi_byte #(
    parameter int unsigned DivW = 7
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [DivW-1:0] half_i,
    input  logic [7:0]      tx_i,
    output logic            busy_o,
    output logic            byte_done_o,
    output logic [7:0]      rx_o,
    output logic            sclk_o,
    output logic            mosi_o,
    input  logic            miso_i
);

    logic            active_q, active_d;
    logic            sclk_q, sclk_d;
    logic [DivW-1:0] cnt_q, cnt_d;
    logic [DivW-1:0] half_q, half_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      tx_q, tx_d;
    logic [7:0]      rx_q, rx_d;
    logic            tick;

    assign tick = active_q && (cnt_q == half_q - DivW'(1));

    always_comb begin
        active_d = active_q;
        sclk_d   = sclk_q;
        cnt_d    = cnt_q;
        half_d   = half_q;
        bit_d    = bit_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        if (tick) begin
            cnt_d = '0;
            if (!sclk_q) begin
                sclk_d = 1'b1;
                rx_d   = {rx_q[6:0], miso_i};
            end else begin
                // Shift in ones so MOSI idles high once the byte is out.
                sclk_d = 1'b0;
                tx_d   = {tx_q[6:0], 1'b1};
                bit_d  = bit_q + 3'd1;
                if (bit_q == 3'd7) active_d = 1'b0;
            end
        end else if (active_q) begin
            cnt_d = cnt_q + DivW'(1);
        end
        // A start on the final falling edge chains the next byte seamlessly.
        if (start_i) begin
            active_d = 1'b1;
            sclk_d   = 1'b0;
            cnt_d    = '0;
            bit_d    = 3'd0;
            tx_d     = tx_i;
            half_d   = half_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q <= 1'b0;
            sclk_q   <= 1'b0;
            cnt_q    <= '0;
            half_q   <= '0;
            bit_q    <= 3'd0;
            tx_q     <= 8'hFF;
            rx_q     <= 8'hFF;
        end else begin
            active_q <= active_d;
            sclk_q   <= sclk_d;
            cnt_q    <= cnt_d;
            half_q   <= half_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
        end
    end

    assign busy_o      = active_q;
    assign byte_done_o = tick && sclk_q && (bit_q == 3'd7);
    assign rx_o        = rx_q;
    assign sclk_o      = sclk_q;
    assign mosi_o      = tx_q[7];

endmodule

// File: rtl/mmc_spi_engine.sv
// Sequencer for MMC/SD SPI mode: init clocking, command + R1 poll, byte I/O, CS release.
module mmc_spi_engine
    import mmc_pkg::*;
#(
    parameter int unsigned SLOW_DIV  = 64,
    parameter int unsigned FAST_DIV  = 2,
    parameter int unsigned CMD_BYTES = 6,
    parameter int unsigned RESP_POLL = 16
) (
    input  logic             clk,
    input  logic             reset,
    mmc_spi_engine_if.slave  bus
);

    localparam int unsigned DivW     = $clog2(((SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV) + 1);
    localparam int unsigned ByteCntW =
        $clog2(mmc_max3(MMC_INIT_BYTES, CMD_BYTES, RESP_POLL) + 1);
    localparam int unsigned CmdW     = 8 * CMD_BYTES;

    mmc_state_e          state_q, state_d;
    logic                cs_q, cs_d;
    logic [7:0]          data_q, data_d;
    logic                to_q, to_d;
    logic                spd_q, spd_d;
    logic [CmdW-1:0]     cmd_q, cmd_d;
    logic [ByteCntW-1:0] cnt_q, cnt_d;

    logic                byte_start, byte_busy, byte_done, spd_now;
    logic [7:0]          byte_tx, byte_rx;
    logic [DivW-1:0]     byte_half;
    logic                req_any;

    assign req_any   = bus.init | bus.stop | bus.send | bus.wr | bus.rd;
    assign byte_half = spd_now ? DivW'(FAST_DIV) : DivW'(SLOW_DIV);

    always_comb begin
        state_d    = state_q;
        cs_d       = cs_q;
        data_d     = data_q;
        to_d       = to_q;
        spd_d      = spd_q;
        cmd_d      = cmd_q;
        cnt_d      = cnt_q;
        spd_now    = spd_q;
        byte_start = 1'b0;
        byte_tx    = MMC_IDLE_BYTE;
        unique case (state_q)
            StIdle: begin
                // The divider must follow the live speed input on the accept cycle.
                spd_now = bus.speed;
                if (req_any) begin
                    to_d       = 1'b0;
                    spd_d      = bus.speed;
                    cnt_d      = '0;
                    byte_start = 1'b1;
                    if (bus.init) begin
                        state_d = StInit;
                        cs_d    = 1'b1;
                    end else if (bus.stop) begin
                        state_d = StStop;
                        cs_d    = 1'b1;
                    end else if (bus.send) begin
                        state_d = StCmd;
                        cs_d    = 1'b0;
                        byte_tx = bus.cmd[CmdW-1 -: 8];
                        cmd_d   = bus.cmd << 8;
                    end else begin
                        state_d = StXfer;
                        cs_d    = 1'b0;
                        if (bus.wr) byte_tx = bus.data_in;
                    end
                end
            end
            StInit: begin
                if (byte_done) begin
                    if (cnt_q == ByteCntW'(MMC_INIT_BYTES - 1)) begin
                        state_d = StDone;
                    end else begin
                        cnt_d      = cnt_q + ByteCntW'(1);
                        byte_start = 1'b1;
                    end
                end
            end
            StCmd: begin
                if (byte_done) begin
                    byte_start = 1'b1;
                    if (cnt_q == ByteCntW'(CMD_BYTES - 1)) begin
                        state_d = StResp;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + ByteCntW'(1);
                        byte_tx = cmd_q[CmdW-1 -: 8];
                        cmd_d   = cmd_q << 8;
                    end
                end
            end
            StResp: begin
                if (byte_done) begin
                    if (byte_rx != MMC_IDLE_BYTE) begin
                        data_d  = byte_rx;
                        state_d = StDone;
                    end else if (cnt_q == ByteCntW'(RESP_POLL - 1)) begin
                        data_d  = MMC_IDLE_BYTE;
                        to_d    = 1'b1;
                        state_d = StDone;
                    end else begin
                        cnt_d      = cnt_q + ByteCntW'(1);
                        byte_start = 1'b1;
                    end
                end
            end
            StXfer: begin
                if (byte_done) begin
                    data_d  = byte_rx;
                    state_d = StDone;
                end
            end
            StStop: begin
                if (byte_done) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cs_q    <= 1'b1;
            data_q  <= MMC_IDLE_BYTE;
            to_q    <= 1'b0;
            spd_q   <= 1'b0;
            cmd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cs_q    <= cs_d;
            data_q  <= data_d;
            to_q    <= to_d;
            spd_q   <= spd_d;
            cmd_q   <= cmd_d;
            cnt_q   <= cnt_d;
        end
    end

    mmc_spi_byte #(
        .DivW (DivW)
    ) u_byte (
        .clk_i       (clk),
        .rst_ni      (reset),
        .start_i     (byte_start),
        .half_i      (byte_half),
        .tx_i        (byte_tx),
        .busy_o      (byte_busy),
        .byte_done_o (byte_done),
        .rx_o        (byte_rx),
        .sclk_o      (bus.mmc_sclk),
        .mosi_o      (bus.mmc_do),
        .miso_i      (bus.mmc_di)
    );

    // The shifter only takes a new byte when idle or on its final edge.
    a_start_ok: assert property (@(posedge clk) disable iff (!reset)
        byte_start |-> (!byte_busy || byte_done));

    assign bus.busy      = (state_q != StIdle) && (state_q != StDone);
    assign bus.done      = (state_q == StDone);
    assign bus.timeout   = to_q;
    assign bus.data_out  = data_q;
    assign bus.state_out = state_q;
    assign bus.mmc_cs    = cs_q;

endmodule
